// File: rtl/hpdmc_cmd_checker_pkg.sv
// Shared command encodings, error-bit indices and counter widths for the
// HPDMC command-bus checker.
package hpdmc_chk_pkg;

  // {ras_n, cas_n, we_n} with cs_n low; 3'b110 (burst stop) is not tracked.
  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_NOP   = 3'b111
  } cmd_e;

  localparam int ERR_ACT_OPEN  = 0;
  localparam int ERR_TRP       = 1;
  localparam int ERR_RW_CLOSED = 2;
  localparam int ERR_TRCD      = 3;
  localparam int ERR_REF_OPEN  = 4;
  localparam int ERR_TRFC      = 5;
  localparam int ERR_TREFI     = 6;
  localparam int ERR_LMR       = 7;
  localparam int NUM_ERR       = 8;

  localparam int NUM_BANKS = 4;
  localparam int TRP_W     = 3;
  localparam int TRCD_W    = 3;
  localparam int RFC_W     = 4;
  localparam int REFI_W    = 11;
  localparam int AGE_W     = 12;
  localparam int CNT_W     = 16;

  // Deselect is indistinguishable from NOP as far as the SDRAM is concerned.
  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    if (cs_n) return CMD_NOP;
    return cmd_e'({ras_n, cas_n, we_n});
  endfunction

endpackage

// File: rtl/hpdmc_cmd_checker_bank.sv
// Per-bank tracker: open flag, open row and the tRP / tRCD countdowns.
module hpdmc_chk_bank
  import hpdmc_chk_pkg::*;
#(
  parameter int rowdepth = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                act,
  input  logic                pre,
  input  logic [rowdepth-1:0] row_in,
  input  logic [TRP_W-1:0]    tim_rp,
  input  logic [TRCD_W-1:0]   tim_rcd,
  output logic                open,
  output logic [rowdepth-1:0] row,
  output logic                trp_ok,
  output logic                trcd_ok
);

  logic                open_q, open_d;
  logic [rowdepth-1:0] row_q, row_d;
  logic [TRP_W-1:0]    trp_q, trp_d;
  logic [TRCD_W-1:0]   trcd_q, trcd_d;

  // A reload on this edge wins over the free-running decrement.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    trp_d  = (trp_q != '0) ? trp_q - 1'b1 : '0;
    trcd_d = (trcd_q != '0) ? trcd_q - 1'b1 : '0;
    if (pre) begin
      open_d = 1'b0;
      trp_d  = tim_rp;
    end
    if (act) begin
      open_d = 1'b1;
      row_d  = row_in;
      trcd_d = tim_rcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      row_q  <= '0;
      trp_q  <= '0;
      trcd_q <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      trp_q  <= trp_d;
      trcd_q <= trcd_d;
    end
  end

  assign open    = open_q;
  assign row     = row_q;
  assign trp_ok  = (trp_q == '0);
  assign trcd_ok = (trcd_q == '0);

endmodule

// File: rtl/hpdmc_cmd_checker.sv
// Passive SDRAM command-bus monitor for HPDMC: bank/timing tracking with sticky
// error flags. Define HPDMC_CHK_COUNTERS_EN to add per-command event counters.
module hpdmc_cmd_checker
  import hpdmc_chk_pkg::*;
#(
  parameter int rowdepth   = 13,
  parameter int refi_slack = 64
) (
  input  logic                 sys_clk,
  input  logic                 sdram_rst_n,
  input  logic                 sdram_cs_n,
  input  logic                 sdram_ras_n,
  input  logic                 sdram_cas_n,
  input  logic                 sdram_we_n,
  input  logic [12:0]          sdram_adr,
  input  logic [1:0]           sdram_ba,
  input  logic [TRP_W-1:0]     tim_rp,
  input  logic [TRCD_W-1:0]    tim_rcd,
  input  logic [REFI_W-1:0]    tim_refi,
  input  logic [RFC_W-1:0]     tim_rfc,
  input  logic                 err_clr,
  output logic [NUM_ERR-1:0]   err_status,
  output logic                 err_pulse,
  output logic [NUM_BANKS-1:0] bank_open,
  input  logic [1:0]           open_row_sel,
  output logic [rowdepth-1:0]  open_row
`ifdef HPDMC_CHK_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]     cnt_act,
  output logic [CNT_W-1:0]     cnt_rd,
  output logic [CNT_W-1:0]     cnt_wr,
  output logic [CNT_W-1:0]     cnt_ref
`endif
);

  cmd_e cmd;
  logic is_act, is_pre, is_rw, is_ref, is_lmr, is_cmd;

  logic [NUM_BANKS-1:0] bank_act, bank_pre;
  logic [NUM_BANKS-1:0] open_w, trp_ok_w, trcd_ok_w;
  logic [rowdepth-1:0]  row_w [NUM_BANKS];

  logic [RFC_W-1:0]   rfc_q, rfc_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               armed_q, armed_d;
  logic [AGE_W-1:0]   refi_limit;
  logic               refi_fire;
  logic [NUM_ERR-1:0] err_new;
  logic [NUM_ERR-1:0] err_status_q, err_status_d;
  logic               err_pulse_q, err_pulse_d;

  always_comb begin
    cmd    = decode_cmd(sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n);
    is_act = (cmd == CMD_ACT);
    is_pre = (cmd == CMD_PRE);
    is_rw  = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    is_ref = (cmd == CMD_REF);
    is_lmr = (cmd == CMD_LMR);
    is_cmd = (cmd != CMD_NOP);
  end

  // A10 on a precharge selects every bank regardless of BA.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_act[b] = is_act && (sdram_ba == b[1:0]);
      bank_pre[b] = is_pre && (sdram_adr[10] || (sdram_ba == b[1:0]));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    hpdmc_chk_bank #(.rowdepth(rowdepth)) u_bank (
      .clk     (sys_clk),
      .rst_n   (sdram_rst_n),
      .act     (bank_act[g]),
      .pre     (bank_pre[g]),
      .row_in  (sdram_adr[rowdepth-1:0]),
      .tim_rp  (tim_rp),
      .tim_rcd (tim_rcd),
      .open    (open_w[g]),
      .row     (row_w[g]),
      .trp_ok  (trp_ok_w[g]),
      .trcd_ok (trcd_ok_w[g])
    );
  end

  // Refresh-interval watchdog fires once, then stays quiet until the next REF.
  always_comb begin
    refi_limit = {1'b0, tim_refi} + AGE_W'(refi_slack);
    refi_fire  = armed_q && (age_q > refi_limit);
    rfc_d      = (rfc_q != '0) ? rfc_q - 1'b1 : '0;
    age_d      = (age_q == '1) ? age_q : age_q + 1'b1;
    armed_d    = refi_fire ? 1'b0 : armed_q;
    if (is_ref) begin
      rfc_d   = tim_rfc;
      age_d   = '0;
      armed_d = 1'b1;
    end
  end

  always_comb begin
    err_new                = '0;
    err_new[ERR_ACT_OPEN]  = is_act && open_w[sdram_ba];
    err_new[ERR_TRP]       = is_act && !trp_ok_w[sdram_ba];
    err_new[ERR_RW_CLOSED] = is_rw && !open_w[sdram_ba];
    err_new[ERR_TRCD]      = is_rw && !trcd_ok_w[sdram_ba];
    err_new[ERR_REF_OPEN]  = is_ref && (|open_w);
    err_new[ERR_TRFC]      = is_cmd && (rfc_q != '0);
    err_new[ERR_TREFI]     = refi_fire;
    err_new[ERR_LMR]       = is_lmr && ((|open_w) || (rfc_q != '0));
    // A fresh error outranks a same-cycle clear.
    err_status_d = (err_clr ? '0 : err_status_q) | err_new;
    err_pulse_d  = |err_new;
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      rfc_q        <= '0;
      age_q        <= '0;
      armed_q      <= 1'b1;
      err_status_q <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      rfc_q        <= rfc_d;
      age_q        <= age_d;
      armed_q      <= armed_d;
      err_status_q <= err_status_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign err_status = err_status_q;
  assign err_pulse  = err_pulse_q;
  assign bank_open  = open_w;
  assign open_row   = row_w[open_row_sel];

`ifdef HPDMC_CHK_COUNTERS_EN
  logic [CNT_W-1:0] cnt_act_q, cnt_act_d;
  logic [CNT_W-1:0] cnt_rd_q, cnt_rd_d;
  logic [CNT_W-1:0] cnt_wr_q, cnt_wr_d;
  logic [CNT_W-1:0] cnt_ref_q, cnt_ref_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic hit,
                                               input logic clr);
    if (clr) return '0;
    if (hit && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    cnt_act_d = sat_inc(cnt_act_q, is_act, err_clr);
    cnt_rd_d  = sat_inc(cnt_rd_q, cmd == CMD_READ, err_clr);
    cnt_wr_d  = sat_inc(cnt_wr_q, cmd == CMD_WRITE, err_clr);
    cnt_ref_d = sat_inc(cnt_ref_q, is_ref, err_clr);
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      cnt_act_q <= '0;
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_ref_q <= '0;
    end else begin
      cnt_act_q <= cnt_act_d;
      cnt_rd_q  <= cnt_rd_d;
      cnt_wr_q  <= cnt_wr_d;
      cnt_ref_q <= cnt_ref_d;
    end
  end

  assign cnt_act = cnt_act_q;
  assign cnt_rd  = cnt_rd_q;
  assign cnt_wr  = cnt_wr_q;
  assign cnt_ref = cnt_ref_q;
`endif

endmodule

// File: tb/tb_hpdmc_cmd_checker.sv
// Self-checking bench for hpdmc_cmd_checker: directed command sequences with
// an expected-status queue compared one cycle after each command edge.
module tb_hpdmc_cmd_checker;
  import hpdmc_chk_pkg::*;

  localparam int ROWDEPTH = 13;

  logic                sys_clk = 1'b0;
  logic                sdram_rst_n;
  logic                sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0]         sdram_adr;
  logic [1:0]          sdram_ba;
  logic [2:0]          tim_rp, tim_rcd;
  logic [10:0]         tim_refi;
  logic [3:0]          tim_rfc;
  logic                err_clr;
  logic [7:0]          err_status;
  logic                err_pulse;
  logic [3:0]          bank_open;
  logic [1:0]          open_row_sel;
  logic [ROWDEPTH-1:0] open_row;
`ifdef HPDMC_CHK_COUNTERS_EN
  logic [15:0]         cnt_act, cnt_rd, cnt_wr, cnt_ref;
`endif

  logic [8:0] exp_q[$];
  logic [7:0] exp_status;
  int         errors = 0;
  int         checks = 0;

  localparam logic [7:0] E_ACT  = 8'h01;
  localparam logic [7:0] E_TRP  = 8'h02;
  localparam logic [7:0] E_RWC  = 8'h04;
  localparam logic [7:0] E_TRCD = 8'h08;
  localparam logic [7:0] E_REFO = 8'h10;
  localparam logic [7:0] E_TRFC = 8'h20;
  localparam logic [7:0] E_REFI = 8'h40;
  localparam logic [7:0] E_LMR  = 8'h80;

  hpdmc_cmd_checker #(.rowdepth(ROWDEPTH), .refi_slack(64)) dut (
    .sys_clk      (sys_clk),
    .sdram_rst_n  (sdram_rst_n),
    .sdram_cs_n   (sdram_cs_n),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_adr    (sdram_adr),
    .sdram_ba     (sdram_ba),
    .tim_rp       (tim_rp),
    .tim_rcd      (tim_rcd),
    .tim_refi     (tim_refi),
    .tim_rfc      (tim_rfc),
    .err_clr      (err_clr),
    .err_status   (err_status),
    .err_pulse    (err_pulse),
    .bank_open    (bank_open),
    .open_row_sel (open_row_sel),
    .open_row     (open_row)
`ifdef HPDMC_CHK_COUNTERS_EN
    ,
    .cnt_act      (cnt_act),
    .cnt_rd       (cnt_rd),
    .cnt_wr       (cnt_wr),
    .cnt_ref      (cnt_ref)
`endif
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_nop();
    sdram_cs_n = 1'b0;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = CMD_NOP;
    sdram_adr = '0;
    sdram_ba  = '0;
    err_clr   = 1'b0;
  endtask

  // Drive one command, queue the expected {err_pulse, err_status}, compare next edge.
  task automatic cyc(input string tag, input cmd_e c, input logic [1:0] ba,
                     input logic [12:0] adr, input logic clr,
                     input logic [7:0] exp_new, input logic cs = 1'b0);
    logic [8:0] e;
    @(negedge sys_clk);
    sdram_cs_n = cs;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba  = ba;
    sdram_adr = adr;
    err_clr   = clr;
    exp_status = (clr ? 8'h00 : exp_status) | exp_new;
    exp_q.push_back({|exp_new, exp_status});
    @(posedge sys_clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, {23'b0, err_pulse, err_status}, {23'b0, e});
    set_nop();
  endtask

  task automatic nops(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, CMD_NOP, 2'd0, 13'd0, 1'b0, 8'h00);
  endtask

  initial begin
    sdram_rst_n  = 1'b0;
    set_nop();
    tim_rp       = 3'd2;
    tim_rcd      = 3'd2;
    tim_rfc      = 4'd8;
    tim_refi     = 11'd2047;
    open_row_sel = 2'd0;
    exp_status   = 8'h00;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_status", {24'b0, err_status}, 32'h0);
    chk("rst_pulse", {31'b0, err_pulse}, 32'h0);
    chk("rst_open", {28'b0, bank_open}, 32'h0);
    @(negedge sys_clk);
    sdram_rst_n = 1'b1;

    // Legal PRE -> ACT -> READ on bank 0
    cyc("legal_pre", CMD_PRE, 2'd0, 13'h000, 1'b0, 8'h00);
    nops("legal_nop", 2);
    cyc("legal_act", CMD_ACT, 2'd0, 13'h123, 1'b0, 8'h00);
    nops("legal_nop", 2);
    cyc("legal_rd", CMD_READ, 2'd0, 13'h000, 1'b0, 8'h00);
    chk("legal_open", {28'b0, bank_open}, 32'h1);
    open_row_sel = 2'd0;
    #1;
    chk("legal_row", {19'b0, open_row}, 32'h123);

    // tRP violation on bank 1; pulse must drop after one cycle
    cyc("trp_pre", CMD_PRE, 2'd1, 13'h000, 1'b0, 8'h00);
    cyc("trp_act", CMD_ACT, 2'd1, 13'h055, 1'b0, E_TRP);
    cyc("trp_after", CMD_NOP, 2'd0, 13'h000, 1'b0, 8'h00);
    chk("trp_open", {28'b0, bank_open}, 32'h3);
    open_row_sel = 2'd1;
    #1;
    chk("trp_row", {19'b0, open_row}, 32'h055);
    cyc("trp_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);

    // Access to a closed bank, then READ too soon after ACT
    cyc("wr_closed", CMD_WRITE, 2'd2, 13'h000, 1'b0, E_RWC);
    cyc("rcd_act", CMD_ACT, 2'd3, 13'h0F0, 1'b0, 8'h00);
    cyc("rcd_rd", CMD_READ, 2'd3, 13'h000, 1'b0, E_TRCD);
    cyc("rcd_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);
    chk("rcd_open", {28'b0, bank_open}, 32'hB);

    // ACT to an already open bank replaces the row
    cyc("act_open", CMD_ACT, 2'd0, 13'h0AA, 1'b0, E_ACT);
    open_row_sel = 2'd0;
    #1;
    chk("act_open_row", {19'b0, open_row}, 32'h0AA);
    cyc("act_open_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);
    nops("pre_ref_nop", 1);

    // Refresh with banks open, then commands inside tRFC
    cyc("ref_open", CMD_REF, 2'd0, 13'h000, 1'b0, E_REFO);
    cyc("ref_desel", CMD_LMR, 2'd0, 13'h000, 1'b0, 8'h00, 1'b1);
    cyc("trfc_rd", CMD_READ, 2'd0, 13'h000, 1'b0, E_TRFC);
    cyc("trfc_lmr", CMD_LMR, 2'd0, 13'h000, 1'b0, E_TRFC | E_LMR);
    cyc("trfc_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);
    cyc("trfc_preall", CMD_PRE, 2'd2, 13'h400, 1'b0, E_TRFC);
    chk("preall_open", {28'b0, bank_open}, 32'h0);
    nops("trfc_wait", 3);
    cyc("trfc_end_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);
    cyc("lmr_legal", CMD_LMR, 2'd0, 13'h000, 1'b0, 8'h00);

    // ACT one cycle short of tRP, colliding with a clear
    cyc("trp1_pre", CMD_PRE, 2'd2, 13'h000, 1'b0, 8'h00);
    nops("trp1_nop", 1);
    cyc("trp1_act_clr", CMD_ACT, 2'd2, 13'h011, 1'b1, E_TRP);
    cyc("trp1_preall", CMD_PRE, 2'd0, 13'h400, 1'b0, 8'h00);
    cyc("trp1_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);

    // Refresh starvation: limit 100+64, flagged once
    cyc("refi_ref", CMD_REF, 2'd0, 13'h000, 1'b0, 8'h00);
    tim_refi = 11'd100;
    for (int i = 1; i <= 175; i++)
      cyc("refi_wait", CMD_NOP, 2'd0, 13'h000, 1'b0, (i == 166) ? E_REFI : 8'h00);
    cyc("refi_rearm", CMD_REF, 2'd0, 13'h000, 1'b0, 8'h00);
    cyc("refi_clr", CMD_NOP, 2'd0, 13'h000, 1'b1, 8'h00);
    tim_refi = 11'd2047;
    nops("refi_settle", 8);

    // Asynchronous reset with a bank open and an error pending
    cyc("rst_act", CMD_ACT, 2'd0, 13'h0321, 1'b0, 8'h00);
    cyc("rst_wr", CMD_WRITE, 2'd1, 13'h000, 1'b0, E_RWC);
    chk("pre_rst_open", {28'b0, bank_open}, 32'h1);
    #2;
    sdram_rst_n = 1'b0;
    #1;
    chk("arst_status", {24'b0, err_status}, 32'h0);
    chk("arst_pulse", {31'b0, err_pulse}, 32'h0);
    chk("arst_open", {28'b0, bank_open}, 32'h0);
`ifdef HPDMC_CHK_COUNTERS_EN
    chk("arst_cnt", {cnt_act | cnt_rd, cnt_wr | cnt_ref}, 32'h0);
`endif
    exp_status = 8'h00;
    @(negedge sys_clk);
    sdram_rst_n = 1'b1;
    nops("post_rst", 2);
    cyc("post_rst_rd", CMD_READ, 2'd0, 13'h000, 1'b0, E_RWC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpdmc_cmd_checker.md
Name: hpdmc_cmd_checker

Overview:
- Passive responder-side monitor on the SDRAM command bus driven by the HPDMC management FSM.
- Decodes every command at the pins and tracks per-bank open-row state and tRP/tRCD/tRFC/tREFI timing.
- Raises sticky error flags plus a one-cycle error pulse.
- Sits beside the SDRAM pads in simulation and FPGA bring-up builds. It drives nothing onto the bus.

Parameters:
- rowdepth, 13, width of the row address captured on ACTIVATE.
- refi_slack, 64, cycles beyond tim_refi tolerated before flagging a refresh-interval violation.

Ports:
- sys_clk  in  1  system clock; all sampling on posedge.
- sdram_rst_n  in  1  asynchronous active-low reset.
- sdram_cs_n  in  1  SDRAM chip select, sampled.
- sdram_ras_n  in  1  SDRAM RAS, sampled.
- sdram_cas_n  in  1  SDRAM CAS, sampled.
- sdram_we_n  in  1  SDRAM WE, sampled.
- sdram_adr  in  13  SDRAM address (A10 = precharge-all).
- sdram_ba  in  2  bank address.
- tim_rp  in  3  tRP setting, same encoding as the controller.
- tim_rcd  in  3  tRCD setting.
- tim_refi  in  11  tREFI setting.
- tim_rfc  in  4  tRFC setting.
- err_clr  in  1  synchronous clear of err_status.
- err_status  out  8  sticky error bits.
- err_pulse  out  1  high one cycle after any violating command.
- bank_open  out  4  per-bank open flag.
- open_row_sel  in  2  bank selector for open_row.
- open_row  out  rowdepth  open row of the selected bank (combinational mux).

Behaviour:
- Reset (async, sdram_rst_n=0):
  - err_status=0, err_pulse=0, bank_open=0.
  - All bank counters=0, rfc counter=0, refresh age=0.
- Command decode, only when cs_n=0, on {ras_n,cas_n,we_n}:
  - 111 NOP, 011 ACT, 101 READ, 100 WRITE.
  - 010 PRE; PRE with A10=1 is PREALL.
  - 001 REF, 000 LMR.
  - cs_n=1 is DESELECT, treated as NOP.
- Per-bank state (4 instances): open flag, row register, trp_cnt (3b), trcd_cnt (3b).
  - Each counter decrements toward 0 and saturates at 0.
- PRE (bank ba) / PREALL (all banks): clear open flag(s); load trp_cnt=tim_rp. PRE to a closed bank is legal and still reloads trp_cnt.
- ACT: load open=1, row=sdram_adr[rowdepth-1:0], trcd_cnt=tim_rcd.
  - bank already open -> ERR_ACT_OPEN (bit0).
  - trp_cnt!=0 -> ERR_TRP (bit1).
  - State updates regardless of error.
  - Legal ACT therefore occurs >= tim_rp+1 cycles after PRE, matching reload-then-count-to-zero controller semantics.
- READ/WRITE:
  - bank closed -> ERR_RW_CLOSED (bit2).
  - trcd_cnt!=0 -> ERR_TRCD (bit3).
- REF: load rfc_cnt=tim_rfc; clear refresh age.
  - any bank open -> ERR_REF_OPEN (bit4).
- Any non-NOP command while rfc_cnt!=0 -> ERR_TRFC (bit5). The command is still decoded normally.
- Refresh age: 12-bit counter, increments every cycle, saturates at 4095, cleared by REF.
  - When age > tim_refi+refi_slack (12-bit compare), set ERR_TREFI (bit6) once per interval via an armed flag re-armed by REF.
- LMR with any bank open or rfc_cnt!=0 -> ERR_LMR (bit7).
- Timing:
  - Errors are registered and appear in err_status and err_pulse the cycle after the offending command edge. Latency is 1.
  - bank_open updates with the same 1-cycle latency.
- Simultaneous events:
  - err_clr in the same cycle as a new error: new error wins, so the bit is set.
  - Several errors from one command all set their bits, with a single err_pulse.
  - Counter reload has priority over decrement.
- Reset mid-burst returns all tracking to closed and idle immediately, with no error reported.

Optional Feature:
- Macro HPDMC_CHK_COUNTERS_EN.
- When defined:
  - Adds outputs cnt_act, cnt_rd, cnt_wr, cnt_ref, each 16 bits.
  - Each is a saturating count (stops at 16'hFFFF) of the decoded commands.
  - Cleared by reset and by err_clr.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package hpdmc_chk_pkg holds:
  - Command encodings CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_LMR.
  - Error bit indices ERR_ACT_OPEN..ERR_LMR.
  - Counter widths.
- One sub-module hpdmc_chk_bank: per-bank open/row/trp/trcd tracker.
  - Inputs: decoded act/pre/rw strobes and timing values.
  - Outputs: open, row, trp_ok, trcd_ok.
  - Instantiated four times.

Test Plan:
- Legal sequence: tim_rp=2, tim_rcd=2. PRE b0, 2 NOPs, ACT b0 row 0x123, 2 NOPs, READ b0 -> err_status=0; bank_open=0001; open_row=0x123 with sel=0.
- tRP violation: PRE b1, then ACT b1 next cycle with tim_rp=2 -> err_status bit1 set; err_pulse high exactly 1 cycle; bank_open[1]=1.
- Closed/early access: WRITE to closed b2 -> bit2. ACT b3 then READ b3 next cycle with tim_rcd=2 -> bit3.
- Refresh: REF with b0 open -> bit4. Non-NOP command 1 cycle after REF with tim_rfc=8 -> bit5.
- Refresh starvation: tim_refi=100, refi_slack=64, no REF for 170 cycles -> bit6 set once at cycle 165. REF re-arms; err_clr clears to 0.
- Reset mid-operation: assert sdram_rst_n=0 asynchronously while b0 open and err bits set -> bank_open=0 and err_status=0 immediately. With HPDMC_CHK_COUNTERS_EN, all cnt_*=0.
